// File: rtl/mux_rr_pipe.sv
// N-input registered multiplexer with a single-entry output stage, selecting
// either a statically addressed channel or the next valid channel in round-robin order.
module mux_rr_pipe #(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 4,
    localparam int SELW   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [NUM_IN*WIDTH-1:0] InData,
    input  logic [NUM_IN-1:0]       InValid,
    output logic [NUM_IN-1:0]       InReady,
    input  logic [SELW-1:0]         Sel,
    input  logic                    Mode,
    output logic [WIDTH-1:0]        OutData,
    output logic [SELW-1:0]         OutSrc,
    output logic                    OutValid,
    input  logic                    OutReady
);

    // Handshake: a word moves on a rising edge when valid and ready are both high
    // in the preceding cycle; a producer holds valid and data steady until taken.
    // OutReady feeds InReady combinationally so a draining slot refills with no bubble.

    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_src;
    logic             r_out_valid;
    logic [SELW-1:0]  r_rr_ptr;

    logic             w_load;
    logic             w_grant_vld;
    logic [SELW-1:0]  w_grant;
    logic [WIDTH-1:0] w_grant_data;

    assign w_load = ~r_out_valid | OutReady;

    always_comb begin
        int idx;
        w_grant_vld = 1'b0;
        w_grant     = '0;
        idx         = 0;
        if (!Mode) begin
            // Out-of-range Sel values simply never match a channel.
            for (int i = 0; i < NUM_IN; i++) begin
                if (Sel == SELW'(i) && InValid[i]) begin
                    w_grant_vld = 1'b1;
                    w_grant     = SELW'(i);
                end
            end
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                idx = (int'(r_rr_ptr) + k) % NUM_IN;
                if (!w_grant_vld && InValid[idx]) begin
                    w_grant_vld = 1'b1;
                    w_grant     = SELW'(idx);
                end
            end
        end
    end

    assign w_grant_data = InData[int'(w_grant)*WIDTH +: WIDTH];

    always_comb begin
        InReady = '0;
        if (w_load && w_grant_vld && !Rst) begin
            InReady[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_rr_ptr    <= '0;
        end else if (w_load) begin
            if (w_grant_vld) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_grant_data;
                r_out_src   <= w_grant;
                // Pointer only advances past a channel that won under round-robin.
                if (Mode) begin
                    r_rr_ptr <= (int'(w_grant) == NUM_IN - 1) ? '0 : SELW'(int'(w_grant) + 1);
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign OutData  = r_out_data;
    assign OutSrc   = r_out_src;
    assign OutValid = r_out_valid;

endmodule

// File: tb/tb_mux_rr_pipe.sv
// Directed and randomized bench for mux_rr_pipe, checked against a
// transaction-level model of the grant rules and an expected-word queue.
module tb_mux_rr_pipe;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int SW = 2;

    logic            Clk;
    logic            Rst;
    logic [N*W-1:0]  InData;
    logic [N-1:0]    InValid;
    logic [N-1:0]    InReady;
    logic [SW-1:0]   Sel;
    logic            Mode;
    logic [W-1:0]    OutData;
    logic [SW-1:0]   OutSrc;
    logic            OutValid;
    logic            OutReady;

    mux_rr_pipe #(.WIDTH(W), .NUM_IN(N)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .InData   (InData),
        .InValid  (InValid),
        .InReady  (InReady),
        .Sel      (Sel),
        .Mode     (Mode),
        .OutData  (OutData),
        .OutSrc   (OutSrc),
        .OutValid (OutValid),
        .OutReady (OutReady)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    bit              m_valid = 1'b0;
    logic [W-1:0]    m_data  = '0;
    logic [SW-1:0]   m_src   = '0;
    int              m_ptr   = 0;
    logic [SW+W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input bit mode, input int sel, input logic [N-1:0] vld, input int ptr);
        if (!mode) return (sel < N && vld[sel]) ? sel : -1;
        for (int k = 0; k < N; k++) begin
            if (vld[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] chan(input int i);
        return InData[i*W +: W];
    endfunction

    // One clock: check combinational ready, check delivered word, advance model, check outputs.
    task automatic step(input string tag);
        int              g;
        bit              load;
        logic [N-1:0]    exp_rdy;
        logic [SW+W-1:0] got;
        #1;
        g       = model_grant(Mode, int'(Sel), InValid, m_ptr);
        load    = !m_valid || OutReady;
        exp_rdy = (!Rst && load && g >= 0) ? N'(1 << g) : '0;
        check({tag, "/rdy"}, 64'(InReady), 64'(exp_rdy));
        if (!Rst && m_valid && OutReady) begin
            check({tag, "/q_nonempty"}, 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
                got = exp_q.pop_front();
                check({tag, "/deliver"}, 64'({OutSrc, OutData}), 64'(got));
            end
        end
        @(posedge Clk);
        #1;
        if (Rst) begin
            m_valid = 1'b0; m_data = '0; m_src = '0; m_ptr = 0;
            exp_q.delete();
        end else if (load) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = chan(g);
                m_src   = SW'(g);
                exp_q.push_back({SW'(g), chan(g)});
                if (Mode) m_ptr = (g + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
        check({tag, "/valid"}, 64'(OutValid), 64'(m_valid));
        check({tag, "/data"}, 64'(OutData), 64'(m_data));
        check({tag, "/src"}, 64'(OutSrc), 64'(m_src));
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) InData[i*W +: W] = $urandom;
    endtask

    initial begin
        Rst = 1'b1; InValid = '1; OutReady = 1'b1; Mode = 1'b1; Sel = '0;
        rand_data();
        @(posedge Clk); #1;

        // reset held with all channels offering
        step("rst0");
        step("rst1");
        Rst = 1'b0;
        step("rst_release");
        check("first_rr_src", 64'(OutSrc), 64'(0));

        // static select of channel 2
        Mode = 1'b0; Sel = 2'd2; InData[2*W +: W] = 32'hDEADBEEF; InValid = 4'b1111;
        step("static2");
        check("static2_word", 64'(OutData), 64'hDEADBEEF);

        // round-robin from a fresh pointer
        Rst = 1'b1; step("rst_rr"); Rst = 1'b0;
        Mode = 1'b1; InValid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            step("rr_all");
            check("rr_all_seq", 64'(OutSrc), 64'(i % N));
        end
        InValid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            step("rr_1010");
            check("rr_1010_seq", 64'(OutSrc), 64'((i % 2) ? 3 : 1));
        end

        // backpressure hold then refill with no bubble
        Mode = 1'b0; Sel = 2'd1; InData[1*W +: W] = 32'h12345678; InValid = 4'b0010;
        step("bp_load");
        Mode = 1'b1; InValid = 4'b1111; OutReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            step("bp_hold");
            check("bp_hold_word", 64'(OutData), 64'h12345678);
        end
        OutReady = 1'b1;
        step("bp_release");

        // static select of an idle channel drains the stage
        Mode = 1'b0; Sel = 2'd3; InValid = 4'b0111;
        step("nogrant0");
        step("nogrant1");

        // reset discards a held word
        Sel = 2'd0; InValid = 4'b0001; OutReady = 1'b1;
        step("rst_mid_load");
        InValid = '0; OutReady = 1'b0; Rst = 1'b1;
        step("rst_mid");
        Rst = 1'b0; OutReady = 1'b1;
        step("rst_mid_after");
        step("rst_mid_after2");

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            rand_data();
            InValid  = N'($urandom);
            Mode     = 1'($urandom);
            Sel      = SW'($urandom);
            OutReady = ($urandom_range(0, 9) < 7);
            Rst      = ($urandom_range(0, 49) == 0);
            step("rand");
        end
        Rst = 1'b0; InValid = '0; OutReady = 1'b1;
        step("flush");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
